mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Each transaction is captured into holding registers, issued to memory, and held until the memory signals completion. The result is then returned to the owning stage with a one-cycle valid pulse. Arbitration favours data accesses, so the pipeline drains first. A streak limit prevents starvation of fetch, and a watchdog aborts hung transactions.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STREAK, 4, max consecutive data grants while fetch is pending; range 1..15
TIMEOUT, 64, max cycles in a busy state before abort; 0 disables; range 0..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
if_req  in  1  fetch request; held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse: fetch request captured
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched word
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1=write, 0=read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  one-cycle pulse: data request captured
dm_valid  out  1  one-cycle pulse: data access complete
dm_rdata  out  DW  read data
mem_req  out  1  memory access active
mem_we  out  1  write strobe, qualified by mem_req
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs are 0: if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata and err. Streak and watchdog counters are 0. An in-flight access is dropped; mem_req falls without waiting for a clock edge.
- FSM states: IDLE, BUSY_IF, BUSY_DM. All outputs are registered.
- IDLE, arbitration at each rising edge:
  - dm_req only: go to BUSY_DM.
  - if_req only: go to BUSY_IF.
  - Both high: BUSY_DM, unless streak==MAX_STREAK, in which case BUSY_IF.
  - Neither: stay in IDLE.
- On the granting edge:
  - Capture addr, we and wdata into mem_addr, mem_we and mem_wdata. A fetch forces mem_we=0.
  - Set mem_req=1.
  - Pulse the matching gnt for exactly the following cycle.
- Requester rules: the requester holds req and operands stable until it sees gnt. Req high in the gnt cycle itself is ignored (state is busy). Req high afterwards is treated as a new request.
- Streak counter:
  - +1 on each data grant made while if_req=1.
  - Cleared on any fetch grant, and on any data grant made with if_req=0.
  - Saturates at MAX_STREAK.
- BUSY_x with mem_ready=1 at an edge:
  - Return to IDLE and set mem_req=0.
  - Pulse x_valid for 1 cycle.
  - Fetches and data reads latch mem_rdata into x_rdata. Data writes leave dm_rdata unchanged.
  - x_rdata holds its value until the next completion.
- Latency: req high at edge E0 → gnt and mem_req in the cycle after E0. If mem_ready arrives in that cycle, valid is high in the cycle after E1 (2 cycles minimum). IDLE lasts at least 1 cycle between transactions.
- Watchdog:
  - The counter increments each busy cycle without mem_ready and clears on entering IDLE.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT, the next edge aborts: IDLE, mem_req=0, x_valid pulses, x_rdata=0, err=1.
  - err is sticky until reset.
- mem_ready while IDLE is ignored.
- mem_addr, mem_we and mem_wdata hold their last values in IDLE.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x8. Memory returns 0x00221820 with mem_ready one cycle after mem_req → if_gnt in cycle 1, mem_addr=0x8, mem_we=0, if_valid in cycle 2, if_rdata=0x00221820. No dm_* pulses.
2. Data write then read: write dm_addr=0x10, dm_wdata=0x5 (mem_ready after 3 cycles), then a read of 0x10 returning 0x5 → first dm_valid has dm_rdata unchanged; second dm_valid has dm_rdata=0x5. mem_we=1 only during the write.
3. Contention/starvation, MAX_STREAK=4: if_req and dm_req held high with re-requests after each gnt → grant order DM,DM,DM,DM,IF,DM…; streak resets after the IF grant.
4. Timeout, TIMEOUT=8: dm read issued, mem_ready never asserted → after 8 busy cycles, abort: dm_valid pulses with dm_rdata=0, err=1 and stays 1. A following fetch completes normally.
5. Reset mid-transaction: assert reset=0 between clock edges in BUSY_IF → mem_req and all outputs are 0 immediately. After release, no valid pulse occurs for the dropped access and the next request is granted normally.
6. Spurious mem_ready=1 in IDLE, and if_req held through the gnt cycle → no valid pulse and no duplicate issue.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins arbitration, bounded by a streak limit; a watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,

   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_valid,
   output logic [DW-1:0] dm_rdata,

   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,

   output logic          err
);

   typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

   localparam logic [3:0] StreakMax = 4'(MAX_STREAK);
   localparam logic [7:0] WdLimit   = 8'(TIMEOUT);
   localparam bit         WdEn      = (TIMEOUT != 0);

   state_e          state_q, state_d;
   logic [3:0]      streak_q, streak_d;
   logic [7:0]      wd_q, wd_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            if_gnt_q, if_gnt_d;
   logic            dm_gnt_q, dm_gnt_d;
   logic            if_valid_q, if_valid_d;
   logic            dm_valid_q, dm_valid_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
   logic            err_q, err_d;

   logic            grant_dm;
   logic            grant_if;
   logic            abort;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      wd_d        = wd_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      err_d       = err_q;

      // Fetch only overtakes a pending data request once the streak is exhausted.
      grant_dm = dm_req && !(if_req && (streak_q == StreakMax));
      grant_if = if_req && !grant_dm;
      abort    = WdEn && (wd_q == WdLimit);

      unique case (state_q)
         StIdle: begin
            wd_d = '0;
            if (grant_dm) begin
               state_d     = StBusyDm;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               dm_gnt_d    = 1'b1;
               if (!if_req) begin
                  streak_d = '0;
               end else if (streak_q != StreakMax) begin
                  streak_d = streak_q + 4'd1;
               end
            end else if (grant_if) begin
               state_d    = StBusyIf;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
               if_gnt_d   = 1'b1;
               streak_d   = '0;
            end
         end

         StBusyIf, StBusyDm: begin
            if (mem_ready || abort) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               wd_d      = '0;
               if (state_q == StBusyIf) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : '0;
               end else begin
                  dm_valid_d = 1'b1;
                  if (!mem_ready) begin
                     dm_rdata_d = '0;
                  end else if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata;
                  end
               end
               if (!mem_ready) begin
                  err_d = 1'b1;
               end
            end else if (wd_q != 8'hFF) begin
               wd_d = wd_q + 8'd1;
            end
         end

         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         streak_q    <= '0;
         wd_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         wd_q        <= wd_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         err_q       <= err_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and responses are queued
// by the stimulus and checked by a monitor whenever the DUT pulses gnt or valid.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_valid;
   logic [DW-1:0] if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          dm_gnt, dm_valid;
   logic [DW-1:0] dm_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          err;

   mem_port_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .MAX_STREAK (4),
      .TIMEOUT    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_valid  (dm_valid),
      .dm_rdata  (dm_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] rdata;
   } rsp_t;

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];
   gnt_t eg;
   rsp_t er;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ifv = 0, n_dmv = 0, n_ifg = 0, n_dmg = 0;

   int  lat = 1;
   bit  hang = 1'b0;
   bit  spurious = 1'b0;
   int  resp_cnt = 0;
   logic [31:0] tbmem [0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_gnt(input logic is_dm, input logic [31:0] a, input logic we,
                          input logic [31:0] wd);
      gnt_t g;
      g.is_dm = is_dm; g.addr = a; g.we = we; g.wdata = wd;
      gnt_q.push_back(g);
   endtask

   task automatic exp_rsp(input logic is_dm, input logic [31:0] rd);
      rsp_t r;
      r.is_dm = is_dm; r.rdata = rd;
      rsp_q.push_back(r);
   endtask

   // Monitor: pops and compares on every gnt / valid pulse.
   always @(negedge clk) begin
      if (reset) begin
         n_ifv += int'(if_valid);
         n_dmv += int'(dm_valid);
         n_ifg += int'(if_gnt);
         n_dmg += int'(dm_gnt);
         if (if_gnt || dm_gnt) begin
            if (gnt_q.size() == 0) begin
               check("unexpected_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
            end else begin
               eg = gnt_q.pop_front();
               check("gnt_port", {30'd0, if_gnt, dm_gnt}, eg.is_dm ? 32'd1 : 32'd2);
               check("gnt_mem_req", {31'd0, mem_req}, 32'd1);
               check("gnt_mem_addr", mem_addr, eg.addr);
               check("gnt_mem_we", {31'd0, mem_we}, {31'd0, eg.we});
               if (eg.we) check("gnt_mem_wdata", mem_wdata, eg.wdata);
            end
         end
         if (if_valid || dm_valid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_valid", {30'd0, if_valid, dm_valid}, 32'd0);
            end else begin
               er = rsp_q.pop_front();
               check("valid_port", {30'd0, if_valid, dm_valid}, er.is_dm ? 32'd1 : 32'd2);
               check("rdata", er.is_dm ? dm_rdata : if_rdata, er.rdata);
            end
         end
      end
   end

   // Memory responder: mem_ready after lat busy cycles unless hung.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         if (!mem_req) begin
            resp_cnt = 0;
            if (spurious) begin
               mem_ready = 1'b1;
               mem_rdata = 32'hBAD0_0000;
            end
         end else begin
            resp_cnt++;
            if (!hang && resp_cnt == lat) begin
               mem_ready = 1'b1;
               if (mem_we) begin
                  tbmem[mem_addr[9:2]] = mem_wdata;
                  mem_rdata = 32'hDEAD_BEEF;
               end else begin
                  mem_rdata = tbmem[mem_addr[9:2]];
               end
            end
         end
      end
   end

   task automatic do_fetch(input logic [31:0] a, input bit hold);
      int n;
      if_addr = a;
      if_req = 1'b1;
      n = 0;
      while (!if_gnt && n < 60) begin @(posedge clk); #1; n++; end
      check("if_gnt_seen", {31'd0, if_gnt}, 32'd1);
      if (hold) begin @(posedge clk); #1; end
      if_req = 1'b0;
      n = 0;
      while (!if_valid && n < 60) begin @(posedge clk); #1; n++; end
      check("if_valid_seen", {31'd0, if_valid}, 32'd1);
   endtask

   task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd);
      int n;
      dm_we = we;
      dm_addr = a;
      dm_wdata = wd;
      dm_req = 1'b1;
      n = 0;
      while (!dm_gnt && n < 60) begin @(posedge clk); #1; n++; end
      check("dm_gnt_seen", {31'd0, dm_gnt}, 32'd1);
      dm_req = 1'b0;
      n = 0;
      while (!dm_valid && n < 60) begin @(posedge clk); #1; n++; end
      check("dm_valid_seen", {31'd0, dm_valid}, 32'd1);
   endtask

   task automatic settle();
      repeat (3) begin @(posedge clk); #1; end
      check("gnt_q_drained", gnt_q.size(), 32'd0);
      check("rsp_q_drained", rsp_q.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int v0, g0;
      for (int i = 0; i < 256; i++) tbmem[i] = 32'h0;
      tbmem[8'h02] = 32'h0022_1820;  // 0x8
      tbmem[8'h10] = 32'h1111_0040;  // 0x40
      tbmem[8'h11] = 32'h1111_0044;
      tbmem[8'h12] = 32'h1111_0048;
      tbmem[8'h13] = 32'h1111_004C;
      tbmem[8'h14] = 32'h1111_0050;
      tbmem[8'h40] = 32'h2222_0100;  // 0x100
      tbmem[8'h41] = 32'h2222_0104;
      tbmem[8'h43] = 32'h2222_010C;
      tbmem[8'h81] = 32'h3333_0204;  // 0x204

      // Reset state.
      #2;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_gnts", {30'd0, if_gnt, dm_gnt}, 32'd0);
      check("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: fetch only.
      lat = 1;
      exp_gnt(1'b0, 32'h8, 1'b0, 32'h0);
      exp_rsp(1'b0, 32'h0022_1820);
      do_fetch(32'h8, 1'b0);
      settle();
      check("t1_no_dm_valid", n_dmv, 32'd0);
      check("t1_no_dm_gnt", n_dmg, 32'd0);

      // 2: write then read back; the write leaves dm_rdata untouched.
      lat = 3;
      exp_gnt(1'b1, 32'h10, 1'b1, 32'h5);
      exp_rsp(1'b1, 32'h0);
      exp_gnt(1'b1, 32'h10, 1'b0, 32'h0);
      exp_rsp(1'b1, 32'h5);
      do_dm(1'b1, 32'h10, 32'h5);
      do_dm(1'b0, 32'h10, 32'h0);
      settle();

      // 3: contention; four data grants, then fetch, streak restarts.
      lat = 1;
      exp_gnt(1'b1, 32'h40, 1'b0, 32'h0); exp_rsp(1'b1, 32'h1111_0040);
      exp_gnt(1'b1, 32'h44, 1'b0, 32'h0); exp_rsp(1'b1, 32'h1111_0044);
      exp_gnt(1'b1, 32'h48, 1'b0, 32'h0); exp_rsp(1'b1, 32'h1111_0048);
      exp_gnt(1'b1, 32'h4C, 1'b0, 32'h0); exp_rsp(1'b1, 32'h1111_004C);
      exp_gnt(1'b0, 32'h100, 1'b0, 32'h0); exp_rsp(1'b0, 32'h2222_0100);
      exp_gnt(1'b1, 32'h50, 1'b0, 32'h0); exp_rsp(1'b1, 32'h1111_0050);
      exp_gnt(1'b0, 32'h104, 1'b0, 32'h0); exp_rsp(1'b0, 32'h2222_0104);
      fork
         begin
            do_dm(1'b0, 32'h40, 32'h0);
            do_dm(1'b0, 32'h44, 32'h0);
            do_dm(1'b0, 32'h48, 32'h0);
            do_dm(1'b0, 32'h4C, 32'h0);
            do_dm(1'b0, 32'h50, 32'h0);
         end
         begin
            do_fetch(32'h100, 1'b0);
            do_fetch(32'h104, 1'b0);
         end
      join
      settle();

      // 4: watchdog abort on a hung read, then a normal fetch.
      check("t4_err_before", {31'd0, err}, 32'd0);
      hang = 1'b1;
      exp_gnt(1'b1, 32'h20, 1'b0, 32'h0);
      exp_rsp(1'b1, 32'h0);
      dm_we = 1'b0; dm_addr = 32'h20; dm_req = 1'b1;
      n = 0;
      while (!dm_gnt && n < 60) begin @(posedge clk); #1; n++; end
      check("t4_dm_gnt_seen", {31'd0, dm_gnt}, 32'd1);
      dm_req = 1'b0;
      n = 0;
      while (!dm_valid && n < 60) begin @(posedge clk); #1; n++; end
      check("t4_abort_latency", n, 32'd9);
      check("t4_err_set", {31'd0, err}, 32'd1);
      hang = 1'b0;
      exp_gnt(1'b0, 32'h8, 1'b0, 32'h0);
      exp_rsp(1'b0, 32'h0022_1820);
      do_fetch(32'h8, 1'b0);
      settle();
      check("t4_err_sticky", {31'd0, err}, 32'd1);

      // 5: async reset during a fetch drops it silently.
      lat = 5;
      exp_gnt(1'b0, 32'h200, 1'b0, 32'h0);
      if_addr = 32'h200; if_req = 1'b1;
      n = 0;
      while (!if_gnt && n < 60) begin @(posedge clk); #1; n++; end
      check("t5_if_gnt_seen", {31'd0, if_gnt}, 32'd1);
      if_req = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("t5_mem_req", {31'd0, mem_req}, 32'd0);
      check("t5_mem_addr", mem_addr, 32'd0);
      check("t5_err", {31'd0, err}, 32'd0);
      check("t5_if_rdata", if_rdata, 32'd0);
      check("t5_dm_rdata", dm_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      v0 = n_ifv;
      repeat (8) begin @(posedge clk); #1; end
      check("t5_no_valid", n_ifv, v0);
      lat = 1;
      exp_gnt(1'b0, 32'h204, 1'b0, 32'h0);
      exp_rsp(1'b0, 32'h3333_0204);
      do_fetch(32'h204, 1'b0);
      settle();

      // 6: spurious mem_ready in idle, and if_req held through the gnt cycle.
      v0 = n_ifv + n_dmv;
      spurious = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      spurious = 1'b0;
      @(posedge clk); #1;
      check("t6_no_spurious_valid", n_ifv + n_dmv, v0);
      check("t6_mem_req_idle", {31'd0, mem_req}, 32'd0);
      v0 = n_ifv;
      g0 = n_ifg;
      exp_gnt(1'b0, 32'h10C, 1'b0, 32'h0);
      exp_rsp(1'b0, 32'h2222_010C);
      do_fetch(32'h10C, 1'b1);
      repeat (4) begin @(posedge clk); #1; end
      settle();
      check("t6_one_gnt", n_ifg - g0, 32'd1);
      check("t6_one_valid", n_ifv - v0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
